// File: rtl/keccak_f200_pkg.sv
// Shared definitions for the Keccak-f[200] round core: sizes, rho offsets,
// round constants, FSM state type and lane helpers.
package keccak_f200_pkg;

    localparam int unsigned W  = 8;
    localparam int unsigned b  = 25 * W;
    localparam int unsigned NR = 18;

    typedef logic [W-1:0] lane_t;

    // Rotation offsets indexed 5x+y; applied modulo W
    localparam int unsigned RHO [25] = '{
         0, 36,  3, 41, 18,
         1, 44, 10, 45,  2,
        62,  6, 43, 15, 61,
        28, 55, 25, 21, 56,
        27, 20, 39,  8, 14
    };

    localparam lane_t RC [NR] = '{
        8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
        8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80
    };

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UNLOAD = 2'd2
    } state_e;

    function automatic int unsigned lane_idx(int unsigned x, int unsigned y);
        return 5 * x + y;
    endfunction

    function automatic lane_t rotl(lane_t v, int unsigned n);
        int unsigned s;
        s = n % W;
        if (s == 0) return v;
        return lane_t'((v << s) | (v >> (W - s)));
    endfunction

endpackage

// File: rtl/keccak_f200_round.sv
// Combinational Keccak-f[200] round: theta stage followed by rho, pi, chi
// and iota. Lane (x,y) sits at bits [(5x+y)*W +: W].
module keccak_f200_theta
    import keccak_f200_pkg::*;
(
    input  logic [b-1:0] state_in,
    output logic [b-1:0] state_out
);
    lane_t col [5];

    // Column parities, then mix neighbouring columns into every lane
    always_comb begin
        state_out = '0;
        for (int unsigned x = 0; x < 5; x++) begin
            col[x] = '0;
            for (int unsigned y = 0; y < 5; y++)
                col[x] = col[x] ^ state_in[lane_idx(x, y)*W +: W];
        end
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                state_out[lane_idx(x, y)*W +: W] = state_in[lane_idx(x, y)*W +: W]
                    ^ col[(x + 4) % 5] ^ rotl(col[(x + 1) % 5], 1);
    end
endmodule

module keccak_f200_round
    import keccak_f200_pkg::*;
(
    input  logic [b-1:0] state_in,
    input  lane_t        rc,
    output logic [b-1:0] state_out
);
    logic [b-1:0] theta_out;
    lane_t        perm [5][5];

    keccak_f200_theta u_theta (
        .state_in  (state_in),
        .state_out (theta_out)
    );

    // rho + pi into a lane grid, then chi along rows and iota on lane (0,0)
    always_comb begin
        state_out = '0;
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                perm[x][y] = '0;
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                perm[y][(2*x + 3*y) % 5] = rotl(theta_out[lane_idx(x, y)*W +: W],
                                                RHO[lane_idx(x, y)]);
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                state_out[lane_idx(x, y)*W +: W] = perm[x][y]
                    ^ (~perm[(x + 1) % 5][y] & perm[(x + 2) % 5][y]);
        state_out[W-1:0] = state_out[W-1:0] ^ rc;
    end
endmodule

// File: rtl/keccak_f200_round_core.sv
// Port-serial round-based Keccak-f[200] core: 25 lane loads, 18 rounds at
// one per clock, 25 lane unloads. Define KECCAK_F200_ABSORB_EN to XOR input
// lanes into the state and keep the state across blocks (sponge absorb).
module keccak_f200_round_core
    import keccak_f200_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_lane,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_lane,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    state_e       fsm_q, fsm_d;
    logic [b-1:0] state_q, state_d;
    logic [4:0]   lane_cnt_q, lane_cnt_d;
    logic [4:0]   round_cnt_q, round_cnt_d;
    logic [b-1:0] round_out;
    lane_t        cur_lane;
    lane_t        rc;

    keccak_f200_round u_round (
        .state_in  (state_q),
        .rc        (rc),
        .state_out (round_out)
    );

    // Select the current lane and current round constant
    always_comb begin
        cur_lane = '0;
        rc       = '0;
        for (int unsigned i = 0; i < 25; i++)
            if (lane_cnt_q == 5'(i)) cur_lane = state_q[i*W +: W];
        for (int unsigned r = 0; r < NR; r++)
            if (round_cnt_q == 5'(r)) rc = RC[r];
    end

    // Next-state logic for FSM, counters and state register
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        round_cnt_d = round_cnt_q;
        case (fsm_q)
            ST_LOAD: begin
                if (in_valid) begin
                    for (int unsigned i = 0; i < 25; i++)
                        if (lane_cnt_q == 5'(i))
`ifdef KECCAK_F200_ABSORB_EN
                            state_d[i*W +: W] = cur_lane ^ in_lane;
`else
                            state_d[i*W +: W] = in_lane;
`endif
                    if (lane_cnt_q == 5'd24) begin
                        fsm_d      = ST_ROUND;
                        lane_cnt_d = '0;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 5'd1;
                    end
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                if (round_cnt_q == 5'(NR - 1)) begin
                    fsm_d       = ST_UNLOAD;
                    round_cnt_d = '0;
                end else begin
                    round_cnt_d = round_cnt_q + 5'd1;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    if (lane_cnt_q == 5'd24) begin
                        fsm_d      = ST_LOAD;
                        lane_cnt_d = '0;
`ifndef KECCAK_F200_ABSORB_EN
                        state_d    = '0;
`endif
                    end else begin
                        lane_cnt_d = lane_cnt_q + 5'd1;
                    end
                end
            end
            default: fsm_d = ST_LOAD;
        endcase
    end

    // Registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_LOAD;
            state_q     <= '0;
            lane_cnt_q  <= '0;
            round_cnt_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    assign in_ready  = (fsm_q == ST_LOAD);
    assign busy      = (fsm_q == ST_ROUND);
    assign out_valid = (fsm_q == ST_UNLOAD);
    assign out_lane  = (fsm_q == ST_UNLOAD) ? cur_lane : '0;

endmodule

// File: doc/keccak_f200_round_core.md
# keccak_f200_round_core

Port-serial, round-based Keccak-f[200] permutation core. It loads the 200-bit state one W-bit lane per accepted beat and iterates one full round per clock. Each round is theta, rho, pi, chi, iota, with the theta stage fed directly from the state register. The permuted state is returned one lane per beat. It wraps the combinational round logic with the state register, round counter, round-constant generator and both stream handshakes.

## Interface
- `W`, 8: lane width in bits; only 8 is supported (Keccak-f[200]).
- `b`, 200: state width, always 25*W.
- `NR`, 18: rounds per permutation, equal to 12+2*log2(W).
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_lane`  in  W: input lane data.
- `in_valid`  in  1: input lane present.
- `in_ready`  out  1: core accepts an input lane. Reset value 1.
- `out_lane`  out  W: output lane data. Reset value 0.
- `out_valid`  out  1: output lane present. Reset value 0.
- `out_ready`  in  1: consumer accepts the output lane.
- `busy`  out  1: high in ROUND state. Reset value 0.

## Operation
- Lane index i = 5x+y. Lane (x,y) occupies state bits [(5x+y)*W +: W], and lanes travel in ascending i on both ports.
- FSM has three states: LOAD, ROUND and UNLOAD. Reset enters LOAD with lane_cnt=0, round_cnt=0 and the state register cleared to 0.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, lane lane_cnt is written and lane_cnt increments.
  - After the beat with lane_cnt==24 is accepted, the FSM goes to ROUND and lane_cnt clears.
- ROUND:
  - in_ready=0 and busy=1.
  - Each cycle the state register takes round(state, RC[round_cnt]) and round_cnt increments.
  - After the update with round_cnt==NR-1, the FSM goes to UNLOAD and round_cnt clears.
- UNLOAD:
  - out_valid=1 and out_lane = lane lane_cnt of the state register.
  - On out_valid&&out_ready, lane_cnt increments.
  - After lane 24 is accepted, the FSM goes to LOAD and lane_cnt clears.
  - The state register is cleared on that same edge, unless the Configuration macro is defined.
- out_lane is held stable while out_valid&&!out_ready.
- in_valid is ignored outside LOAD.
- Round function:
  - theta: column parities, with the parity of column x+1 rotated left by 1.
  - rho: per-lane rotate left by offset mod W, using the package table.
  - pi: lane (x,y) moves to (y, 2x+3y mod 5).
  - chi: a ^= ~b & c along rows.
  - iota: lane (0,0) ^= RC.
- RC sequence, hex, rounds 0..17: 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80.
- Counter widths: lane_cnt is 5 bits and round_cnt is 5 bits; neither wraps past its terminal value.

## Timing
- Load takes 25 accepted beats, with back-pressure-free throughput of 1 lane per cycle.
- If the last input beat is accepted at edge t:
  - ROUND occupies cycles t+1 .. t+18.
  - out_valid is first high in cycle t+19.
- Minimum permutation period is 25+18+25 = 68 cycles.
- rst=1 overrides every state: outputs reach their reset values on the next edge. An in-progress load, round or unload is discarded.
- Handshake transfers happen only on a valid&&ready edge. Bubbles and stalls of any length are legal.

## Configuration
- Macro: `KECCAK_F200_ABSORB_EN`.
- Defined:
  - LOAD XORs in_lane into the existing lane (sponge absorb) instead of overwriting it.
  - The state is not cleared on leaving UNLOAD, so successive blocks chain.
  - Reset still clears the state.
- Undefined: LOAD overwrites lanes, and the state clears after UNLOAD.

## Structure
- Package `keccak_f200_pkg`:
  - W, b, NR.
  - 25-entry rho offset table: 0 36 3 41 18 / 1 44 10 45 2 / 62 6 43 15 61 / 28 55 25 21 56 / 27 20 39 8 14, indexed 5x+y, used mod W.
  - 18-entry RC table.
  - FSM state enum.
  - Lane-index helper function.
- Sub-module `keccak_f200_round`: the combinational full round (theta through iota), with ports state_in, rc, state_out. It instantiates the existing theta stage. FSM, counters and state register stay in the top.

## Test plan
- Reset: hold rst 2 cycles → in_ready=1, out_valid=0, out_lane=0, busy=0. Load 25 zero lanes and compare all 25 output lanes against the software Keccak-f[200] model, first out_valid exactly 19 cycles after the last accept.
- Random state: load lanes 0x00..0x18 → output equals the model; busy high for exactly 18 cycles.
- Back-pressure:
  - Random in_valid gaps and out_ready low for 5 cycles mid-unload → out_lane stable while stalled.
  - No lane dropped or duplicated.
  - Result matches the model.
- Reset mid-operation: assert rst at round 7, and separately after unload lane 12 → FSM back in LOAD, state zero; a fresh permutation then matches the model.
- Ignore/chaining:
  - Drive in_valid during ROUND/UNLOAD → no effect.
  - With KECCAK_F200_ABSORB_EN, two chained blocks give model(model(A) ^ B).
  - Without it, the second result is model(B).
